// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ID/EX register with stall/flush, operand forwarding,
// ALU with zero flag, and the EX/MEM register feeding the memory stage.
module ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            id_valid,
    input  logic [2:0]      id_alucontrol,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memwrite,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] wb_result,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_zero,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_aluresult,
    output logic [XLEN-1:0] mem_writedata,
    output logic [REGW-1:0] mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memwrite
);

    typedef struct packed {
        logic            valid;
        logic [2:0]      alucontrol;
        logic            alusrc;
        logic            regwrite;
        logic            memwrite;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] aluresult;
        logic [XLEN-1:0] writedata;
        logic [REGW-1:0] rd;
        logic            regwrite;
        logic            memwrite;
    } exmem_t;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;

    logic signed [XLEN-1:0] src_a;
    logic signed [XLEN-1:0] src_b;
    logic        [XLEN-1:0] fwd_b_val;
    logic        [XLEN-1:0] alu_result;

    // Select 11 falls back to the register-file value, same as 00.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] regval,
        input logic [XLEN-1:0] wbval,
        input logic [XLEN-1:0] memval
    );
        logic [XLEN-1:0] r;
        case (sel)
            2'b01:   r = wbval;
            2'b10:   r = memval;
            default: r = regval;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] alu_op(
        input logic [2:0]             op,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = (a < b) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---- ID/EX boundary ----
    always_comb begin
        idex_d = idex_q;
        if (flush_e) begin
            idex_d = '0;
        end else if (!stall_e) begin
            idex_d.valid      = id_valid;
            idex_d.alucontrol = id_alucontrol;
            idex_d.alusrc     = id_alusrc;
            idex_d.regwrite   = id_regwrite;
            idex_d.memwrite   = id_memwrite;
            idex_d.rd1        = id_rd1;
            idex_d.rd2        = id_rd2;
            idex_d.imm        = id_imm;
            idex_d.rs1        = id_rs1;
            idex_d.rs2        = id_rs2;
            idex_d.rd         = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    // ---- EX: forwarding and ALU ----
    always_comb begin
        fwd_b_val  = fwd_mux(fwd_b, idex_q.rd2, wb_result, exmem_q.aluresult);
        src_a      = fwd_mux(fwd_a, idex_q.rd1, wb_result, exmem_q.aluresult);
        src_b      = idex_q.alusrc ? idex_q.imm : fwd_b_val;
        alu_result = alu_op(idex_q.alucontrol, src_a, src_b);
    end

    assign ex_zero = (alu_result == '0);
    assign ex_rs1  = idex_q.rs1;
    assign ex_rs2  = idex_q.rs2;
    assign ex_rd   = idex_q.rd;

    // ---- EX/MEM boundary ----
    // A stalled EX slot must not reach MEM, so it leaves as a bubble; a flush wins over the stall.
    always_comb begin
        exmem_d = '0;
        if (flush_e || !stall_e) begin
            exmem_d.valid     = idex_q.valid;
            exmem_d.aluresult = alu_result;
            exmem_d.writedata = fwd_b_val;
            exmem_d.rd        = idex_q.rd;
            exmem_d.regwrite  = idex_q.regwrite && (idex_q.rd != '0);
            exmem_d.memwrite  = idex_q.memwrite && idex_q.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) exmem_q <= '0;
        else       exmem_q <= exmem_d;
    end

    assign mem_valid     = exmem_q.valid;
    assign mem_aluresult = exmem_q.aluresult;
    assign mem_writedata = exmem_q.writedata;
    assign mem_rd        = exmem_q.rd;
    assign mem_regwrite  = exmem_q.regwrite;
    assign mem_memwrite  = exmem_q.memwrite;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases followed by randomized traffic
// compared against a cycle-level behavioural model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall_e, flush_e;
    logic        id_valid, id_alusrc, id_regwrite, id_memwrite;
    logic [2:0]  id_alucontrol;
    logic [31:0] id_rd1, id_rd2, id_imm, wb_result;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd;
    logic        ex_zero, mem_valid, mem_regwrite, mem_memwrite;
    logic [31:0] mem_aluresult, mem_writedata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .id_valid(id_valid), .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memwrite(id_memwrite),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_result(wb_result),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_zero(ex_zero),
        .mem_valid(mem_valid), .mem_aluresult(mem_aluresult), .mem_writedata(mem_writedata),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite)
    );

    // Reference model state: the instruction sitting in EX and the one sitting in MEM.
    typedef struct {
        bit          valid;
        bit [2:0]    op;
        bit          alusrc, rw, mw;
        bit [31:0]   rd1, rd2, imm;
        bit [4:0]    rs1, rs2, rd;
    } ex_slot_t;

    typedef struct {
        bit          valid;
        bit [31:0]   res, wd;
        bit [4:0]    rd;
        bit          rw, mw;
    } mem_slot_t;

    ex_slot_t  m_ex;
    mem_slot_t m_mem;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] r,
                                       input bit [31:0] wb, input bit [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return r;
    endfunction

    function automatic bit [31:0] ref_alu(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [31:0] ref_result();
        bit [31:0] a, b;
        a = pick(fwd_a, m_ex.rd1, wb_result, m_mem.res);
        b = m_ex.alusrc ? m_ex.imm : pick(fwd_b, m_ex.rd2, wb_result, m_mem.res);
        return ref_alu(m_ex.op, a, b);
    endfunction

    // One clock: check EX combinational output, advance model across the edge, check registers.
    task automatic step();
        ex_slot_t  nx;
        mem_slot_t nm;
        bit [31:0] res;
        #1;
        res = ref_result();
        check("ex_zero", 32'(ex_zero), 32'(res == 32'd0));
        nx = m_ex;
        nm = '{default: 0};
        if (reset || flush_e) begin
            nx = '{default: 0};
        end else if (!stall_e) begin
            nx = '{id_valid, id_alucontrol, id_alusrc, id_regwrite, id_memwrite,
                   id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd};
        end
        if (!reset && (flush_e || !stall_e)) begin
            nm.valid = m_ex.valid;
            nm.res   = res;
            nm.wd    = pick(fwd_b, m_ex.rd2, wb_result, m_mem.res);
            nm.rd    = m_ex.rd;
            nm.rw    = m_ex.rw && (m_ex.rd != 5'd0);
            nm.mw    = m_ex.mw && m_ex.valid;
        end
        @(posedge clk);
        #1;
        m_ex  = nx;
        m_mem = nm;
        check("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
        check("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
        check("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
        check("mem_valid", 32'(mem_valid), 32'(m_mem.valid));
        check("mem_aluresult", mem_aluresult, m_mem.res);
        check("mem_writedata", mem_writedata, m_mem.wd);
        check("mem_rd", 32'(mem_rd), 32'(m_mem.rd));
        check("mem_regwrite", 32'(mem_regwrite), 32'(m_mem.rw));
        check("mem_memwrite", 32'(mem_memwrite), 32'(m_mem.mw));
    endtask

    task automatic issue(input bit v, input bit [2:0] op, input bit src, input bit rw, input bit mw,
                         input bit [31:0] r1, input bit [31:0] r2, input bit [31:0] im,
                         input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] d);
        id_valid = v; id_alucontrol = op; id_alusrc = src; id_regwrite = rw; id_memwrite = mw;
        id_rd1 = r1; id_rd2 = r2; id_imm = im; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    endtask

    task automatic idle();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0; stall_e = 0; flush_e = 0;
        fwd_a = 0; fwd_b = 0; wb_result = 0;
    endtask

    initial begin
        m_ex  = '{default: 0};
        m_mem = '{default: 0};
        idle();
        #3;

        // Reset dominates stall and flush
        reset = 1; stall_e = 1; flush_e = 1;
        issue(1, 3'd1, 0, 1, 1, 32'h1234, 32'h5678, 32'h9, 5'd1, 5'd2, 5'd3);
        step();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_ex_rd", 32'(ex_rd), 32'd0);
        check("rst_result", mem_aluresult, 32'd0);

        // add with immediate
        idle();
        issue(1, 3'd0, 1, 1, 0, 32'd5, 32'd0, 32'hFFFF_FFF4, 5'd1, 5'd2, 5'd3);
        step();
        idle();
        step();
        check("add_result", mem_aluresult, 32'hFFFF_FFF9);
        check("add_valid", 32'(mem_valid), 32'd1);

        // sub to zero
        issue(1, 3'd1, 0, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd4, 5'd5, 5'd6);
        step();
        idle();
        check("sub_zero", 32'(ex_zero), 32'd1);
        step();
        check("sub_result", mem_aluresult, 32'd0);

        // signed slt
        issue(1, 3'd5, 0, 1, 0, 32'h8000_0000, 32'd1, 32'd0, 5'd4, 5'd5, 5'd6);
        step();
        idle();
        step();
        check("slt_result", mem_aluresult, 32'd1);

        // Forwarding from MEM on A and WB on B
        issue(1, 3'd0, 1, 1, 0, 32'h10, 32'd0, 32'd0, 5'd1, 5'd0, 5'd7);
        step();
        issue(1, 3'd3, 0, 0, 1, 32'hAA, 32'h55, 32'd0, 5'd7, 5'd8, 5'd0);
        step();
        idle();
        fwd_a = 2'b10; fwd_b = 2'b01; wb_result = 32'h3;
        step();
        check("fwd_or", mem_aluresult, 32'h13);
        check("fwd_store", mem_writedata, 32'h3);
        check("fwd_memwrite", 32'(mem_memwrite), 32'd1);

        // Two-cycle stall: held instruction issues exactly once
        idle();
        issue(1, 3'd0, 0, 1, 0, 32'd1, 32'd2, 32'd0, 5'd7, 5'd8, 5'd9);
        step();
        for (int i = 0; i < 2; i++) begin
            stall_e = 1;
            issue(1, 3'd2, 0, 1, 0, 32'd9, 32'd9, 32'd0, 5'd12, 5'd13, 5'd14);
            step();
            check("stall_rs1", 32'(ex_rs1), 32'd7);
            check("stall_rd", 32'(ex_rd), 32'd9);
            check("stall_bubble", 32'(mem_valid), 32'd0);
        end
        idle();
        step();
        check("unstall_valid", 32'(mem_valid), 32'd1);
        check("unstall_rd", 32'(mem_rd), 32'd9);
        check("unstall_result", mem_aluresult, 32'd3);
        step();
        check("issue_once", 32'(mem_valid), 32'd0);

        // Flush beats stall
        issue(1, 3'd0, 0, 1, 0, 32'd4, 32'd4, 32'd0, 5'd1, 5'd2, 5'd10);
        step();
        stall_e = 1; flush_e = 1;
        step();
        check("flush_ex_rd", 32'(ex_rd), 32'd0);
        check("flush_mem_valid", 32'(mem_valid), 32'd1);
        idle();
        step();
        check("flush_bubble", 32'(mem_valid), 32'd0);

        // Writes to x0 are suppressed
        issue(1, 3'd0, 0, 1, 0, 32'd4, 32'd4, 32'd0, 5'd1, 5'd2, 5'd0);
        step();
        idle();
        step();
        check("x0_regwrite", 32'(mem_regwrite), 32'd0);
        check("x0_valid", 32'(mem_valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 99) < 2);
            flush_e = ($urandom_range(0, 99) < 10);
            stall_e = ($urandom_range(0, 99) < 15);
            fwd_a   = 2'($urandom_range(0, 3));
            fwd_b   = 2'($urandom_range(0, 3));
            wb_result = (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            issue($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom, (($urandom_range(0, 3) == 0) ? id_rd1 : $urandom),
                  (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31))));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
